// File: rtl/ddr2_cmd_arbiter_if.sv
// Host, scrubber and DDR2 controller command/data/return signals for ddr2_cmd_arbiter.
// slave = arbiter view, master = environment (host + scrubber + controller) view.
interface ddr2_cmd_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 25
);
  logic [2:0]            host_cmd;
  logic [1:0]            host_sz;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic                  host_cmd_put;
  logic                  host_data_put;
  logic [63:0]           host_data_in;
  logic                  host_notfull;
  logic                  host_fetching;
  logic                  host_validout;
  logic [63:0]           host_data_out;
  logic [ADDR_WIDTH-1:0] host_raddr;

  logic [2:0]            scr_cmd;
  logic [1:0]            scr_sz;
  logic [ADDR_WIDTH-1:0] scr_addr;
  logic                  scr_cmd_put;
  logic                  scr_data_put;
  logic [63:0]           scr_data_in;
  logic                  scr_notfull;
  logic                  scr_ready;
  logic                  scr_fetching;
  logic                  scr_validout;
  logic [63:0]           scr_data_out;
  logic [ADDR_WIDTH-1:0] scr_raddr;

  logic [2:0]            ctl_cmd;
  logic [1:0]            ctl_sz;
  logic [ADDR_WIDTH-1:0] ctl_addr;
  logic                  ctl_cmd_put;
  logic                  ctl_data_put;
  logic [63:0]           ctl_data_in;
  logic                  ctl_notfull;
  logic                  ctl_ready;
  logic                  ctl_validout;
  logic [63:0]           ctl_data_out;
  logic [ADDR_WIDTH-1:0] ctl_raddr;
  logic                  ctl_fetching;

  modport slave (
    input  host_cmd, host_sz, host_addr, host_cmd_put, host_data_put, host_data_in, host_fetching,
    output host_notfull, host_validout, host_data_out, host_raddr,
    input  scr_cmd, scr_sz, scr_addr, scr_cmd_put, scr_data_put, scr_data_in, scr_fetching,
    output scr_notfull, scr_ready, scr_validout, scr_data_out, scr_raddr,
    output ctl_cmd, ctl_sz, ctl_addr, ctl_cmd_put, ctl_data_put, ctl_data_in, ctl_fetching,
    input  ctl_notfull, ctl_ready, ctl_validout, ctl_data_out, ctl_raddr
  );

  modport master (
    output host_cmd, host_sz, host_addr, host_cmd_put, host_data_put, host_data_in, host_fetching,
    input  host_notfull, host_validout, host_data_out, host_raddr,
    output scr_cmd, scr_sz, scr_addr, scr_cmd_put, scr_data_put, scr_data_in, scr_fetching,
    input  scr_notfull, scr_ready, scr_validout, scr_data_out, scr_raddr,
    input  ctl_cmd, ctl_sz, ctl_addr, ctl_cmd_put, ctl_data_put, ctl_data_in, ctl_fetching,
    output ctl_notfull, ctl_ready, ctl_validout, ctl_data_out, ctl_raddr
  );
endinterface

// File: rtl/ddr2_cmd_arbiter.sv
// Host/scrubber command arbiter in front of a DDR2 controller with read-return steering.
// Optional DDR2_ARB_STATS_EN builds the scrub-grant / forced-grant statistics counters.
module ddr2_cmd_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 25,
  parameter int unsigned TAG_DEPTH    = 8,
  parameter int unsigned STARVE_LIMIT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  ddr2_cmd_arbiter_if.slave    bus,
  output logic                 host_drop,
  output logic                 tag_underflow,
  output logic [15:0]          stat_scr_grants,
  output logic [15:0]          stat_forced
);
  localparam int unsigned PTR_W  = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BEAT_W = 6;
  localparam logic [2:0]  CMD_SCR = 3'b001;
  localparam logic [2:0]  CMD_BLR = 3'b011;

  function automatic logic is_read(input logic [2:0] cmd);
    return (cmd == CMD_SCR) || (cmd == CMD_BLR);
  endfunction

  // SCR returns one beat, BLR returns 8*(sz+1) beats
  function automatic logic [BEAT_W-1:0] beats_of(input logic [2:0] cmd, input logic [1:0] sz);
    return (cmd == CMD_SCR) ? BEAT_W'(1) : BEAT_W'({sz, 3'b000}) + BEAT_W'(8);
  endfunction

  logic                  pend_valid;
  logic                  pend_has_data;
  logic [2:0]            pend_cmd;
  logic [1:0]            pend_sz;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [63:0]           pend_data;
  logic [STV_W-1:0]      starve;

  logic                  tag_src   [TAG_DEPTH];
  logic [BEAT_W-1:0]     tag_beats [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      tag_cnt;
  logic [BEAT_W-1:0]     head_done;

  logic avail_c, tag_full_c, tag_empty_c, force_c, host_ok_c;
  logic host_grant_c, host_data_c, scr_grant_c, pend_read_c;
  logic push_c, pop_c, beat_c, head_scr_c;

  assign avail_c      = bus.ctl_notfull & bus.ctl_ready;
  assign tag_full_c   = (tag_cnt == CNT_W'(TAG_DEPTH));
  assign tag_empty_c  = (tag_cnt == '0);
  assign force_c      = pend_valid & (starve == STV_W'(STARVE_LIMIT));
  assign host_ok_c    = avail_c & ~force_c & ~tag_full_c;
  assign host_grant_c = bus.host_cmd_put & host_ok_c;
  assign host_data_c  = bus.host_data_put & host_ok_c;
  assign pend_read_c  = is_read(pend_cmd);
  // Forced grants override the host; otherwise any host cmd or data put holds the scrubber off
  assign scr_grant_c  = avail_c & pend_valid & ~(pend_read_c & tag_full_c) &
                        (force_c | (~bus.host_cmd_put & ~bus.host_data_put));
  assign push_c       = (host_grant_c & is_read(bus.host_cmd)) | (scr_grant_c & pend_read_c);

  assign bus.host_notfull = host_ok_c;
  assign bus.scr_notfull  = ~pend_valid & ~tag_full_c;
  assign bus.scr_ready    = bus.ctl_ready;

  // Return path follows the head tag; an empty tag FIFO falls back to the host
  assign head_scr_c        = ~tag_empty_c & tag_src[rd_ptr];
  assign bus.host_validout = bus.ctl_validout & ~head_scr_c;
  assign bus.scr_validout  = bus.ctl_validout & head_scr_c;
  assign bus.host_data_out = bus.ctl_data_out;
  assign bus.scr_data_out  = bus.ctl_data_out;
  assign bus.host_raddr    = bus.ctl_raddr;
  assign bus.scr_raddr     = bus.ctl_raddr;
  assign bus.ctl_fetching  = head_scr_c ? bus.scr_fetching : bus.host_fetching;
  assign beat_c            = bus.ctl_validout & bus.ctl_fetching & ~tag_empty_c;
  assign pop_c             = beat_c & (head_done == (tag_beats[rd_ptr] - BEAT_W'(1)));

  // Registered command/data to the controller
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ctl_cmd_put  <= 1'b0;
      bus.ctl_data_put <= 1'b0;
      bus.ctl_cmd      <= '0;
      bus.ctl_sz       <= '0;
      bus.ctl_addr     <= '0;
      bus.ctl_data_in  <= '0;
    end else begin
      bus.ctl_cmd_put  <= host_grant_c | scr_grant_c;
      bus.ctl_data_put <= host_data_c | (scr_grant_c & pend_has_data);
      if (host_grant_c) begin
        bus.ctl_cmd  <= bus.host_cmd;
        bus.ctl_sz   <= bus.host_sz;
        bus.ctl_addr <= bus.host_addr;
      end else if (scr_grant_c) begin
        bus.ctl_cmd  <= pend_cmd;
        bus.ctl_sz   <= pend_sz;
        bus.ctl_addr <= pend_addr;
      end
      if (host_data_c) begin
        bus.ctl_data_in <= bus.host_data_in;
      end else if (scr_grant_c && pend_has_data) begin
        bus.ctl_data_in <= pend_data;
      end
    end
  end

  // Scrubber pending slot and its starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_has_data <= 1'b0;
      pend_cmd      <= '0;
      pend_sz       <= '0;
      pend_addr     <= '0;
      pend_data     <= '0;
      starve        <= '0;
    end else begin
      if (!pend_valid || scr_grant_c) begin
        starve <= '0;
      end else if (!force_c) begin
        starve <= starve + STV_W'(1);
      end
      if (scr_grant_c) begin
        pend_valid    <= 1'b0;
        pend_has_data <= 1'b0;
      end else if (!pend_valid && bus.scr_cmd_put) begin
        pend_valid    <= 1'b1;
        pend_has_data <= bus.scr_data_put;
        pend_cmd      <= bus.scr_cmd;
        pend_sz       <= bus.scr_sz;
        pend_addr     <= bus.scr_addr;
        pend_data     <= bus.scr_data_in;
      end
    end
  end

  // Outstanding-read tag FIFO control
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
      head_done <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      tag_cnt <= tag_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
      if (pop_c) begin
        head_done <= '0;
      end else if (beat_c) begin
        head_done <= head_done + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      tag_src[wr_ptr]   <= scr_grant_c;
      tag_beats[wr_ptr] <= scr_grant_c ? beats_of(pend_cmd, pend_sz)
                                       : beats_of(bus.host_cmd, bus.host_sz);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_drop     <= 1'b0;
      tag_underflow <= 1'b0;
    end else begin
      if ((bus.host_cmd_put | bus.host_data_put) & ~host_ok_c) host_drop <= 1'b1;
      if (bus.ctl_validout & tag_empty_c) tag_underflow <= 1'b1;
    end
  end

`ifdef DDR2_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_scr_grants <= '0;
      stat_forced     <= '0;
    end else begin
      if (scr_grant_c && (stat_scr_grants != 16'hFFFF)) stat_scr_grants <= stat_scr_grants + 16'd1;
      if (scr_grant_c && force_c && (stat_forced != 16'hFFFF)) stat_forced <= stat_forced + 16'd1;
    end
  end
`else
  assign stat_scr_grants = '0;
  assign stat_forced     = '0;
`endif

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Randomised and directed bench for ddr2_cmd_arbiter against a queue-based reference model.
module tb_ddr2_cmd_arbiter;
  localparam int unsigned AW = 25;
  localparam int unsigned TD = 8;
  localparam int unsigned SL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_drop, tag_underflow;
  logic [15:0] stat_scr_grants, stat_forced;

  ddr2_cmd_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  ddr2_cmd_arbiter #(.ADDR_WIDTH(AW), .TAG_DEPTH(TD), .STARVE_LIMIT(SL)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .host_drop       (host_drop),
    .tag_underflow   (tag_underflow),
    .stat_scr_grants (stat_scr_grants),
    .stat_forced     (stat_forced)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding reads as a queue of {owner, beats still to return}
  typedef struct { bit scr; int rem; } tag_t;
  tag_t tq[$];
  bit              m_pv, m_phd;
  logic [2:0]      m_pcmd;
  logic [1:0]      m_psz;
  logic [AW-1:0]   m_paddr;
  logic [63:0]     m_pdata;
  int              m_starve;
  bit              e_drop, e_under, e_put, e_dput;
  int              e_sg, e_forced;
  logic [2:0]      e_cmd;
  logic [1:0]      e_sz;
  logic [AW-1:0]   e_addr;
  logic [63:0]     e_data;
  bit              obs_hv, obs_sv, obs_hnf;

  function automatic bit is_rd(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b011);
  endfunction

  function automatic int beats(input logic [2:0] c, input logic [1:0] s);
    return (c == 3'b001) ? 1 : 8 * (int'(s) + 1);
  endfunction

  task automatic model_clear();
    tq.delete();
    m_pv = 0; m_phd = 0; m_starve = 0;
    e_drop = 0; e_under = 0; e_put = 0; e_dput = 0; e_sg = 0; e_forced = 0;
  endtask

  task automatic idle_inputs();
    bus.host_cmd = 3'b000; bus.host_sz = 2'b00; bus.host_addr = '0;
    bus.host_cmd_put = 0; bus.host_data_put = 0; bus.host_data_in = '0; bus.host_fetching = 0;
    bus.scr_cmd = 3'b000; bus.scr_sz = 2'b00; bus.scr_addr = '0;
    bus.scr_cmd_put = 0; bus.scr_data_put = 0; bus.scr_data_in = '0; bus.scr_fetching = 0;
    bus.ctl_notfull = 1; bus.ctl_ready = 1; bus.ctl_validout = 0;
    bus.ctl_data_out = '0; bus.ctl_raddr = '0;
    reset = 0;
  endtask

  // One clock: inputs already driven at the falling edge; checks combinational outputs,
  // advances the model, then checks registered outputs after the rising edge.
  task automatic step();
    bit avail, full, frc, hnf, snf, own_scr, hg, hd, sg;
    #1;
    avail   = bus.ctl_notfull && bus.ctl_ready;
    full    = (tq.size() == TD);
    frc     = m_pv && (m_starve == SL);
    hnf     = avail && !frc && !full;
    snf     = !m_pv && !full;
    own_scr = (tq.size() != 0) && tq[0].scr;
    obs_hv  = bus.host_validout;
    obs_sv  = bus.scr_validout;
    obs_hnf = bus.host_notfull;
    check("host_notfull", bus.host_notfull, hnf);
    check("scr_notfull", bus.scr_notfull, snf);
    check("scr_ready", bus.scr_ready, bus.ctl_ready);
    check("host_validout", bus.host_validout, bus.ctl_validout && !own_scr);
    check("scr_validout", bus.scr_validout, bus.ctl_validout && own_scr);
    check("ctl_fetching", bus.ctl_fetching, own_scr ? bus.scr_fetching : bus.host_fetching);
    if (bus.ctl_validout) begin
      check("ret_data", own_scr ? bus.scr_data_out : bus.host_data_out, bus.ctl_data_out);
      check("ret_raddr", own_scr ? bus.scr_raddr : bus.host_raddr, 64'(bus.ctl_raddr));
    end

    hg = 0; sg = 0;
    if (avail) begin
      if (frc) sg = !(is_rd(m_pcmd) && full);
      else if (bus.host_cmd_put) hg = hnf;
      else if (m_pv && !bus.host_data_put) sg = !(is_rd(m_pcmd) && full);
    end
    hd = bus.host_data_put && hnf;

    if (reset) begin
      model_clear();
    end else begin
      e_put  = hg || sg;
      e_dput = hd || (sg && m_phd);
      if (hg) begin
        e_cmd = bus.host_cmd; e_sz = bus.host_sz; e_addr = bus.host_addr;
      end else if (sg) begin
        e_cmd = m_pcmd; e_sz = m_psz; e_addr = m_paddr;
      end
      if (hd) e_data = bus.host_data_in;
      else if (sg && m_phd) e_data = m_pdata;
      if ((bus.host_cmd_put || bus.host_data_put) && !hnf) e_drop = 1;
      if (bus.ctl_validout && tq.size() == 0) e_under = 1;
      if (sg && e_sg < 65535) e_sg++;
      if (sg && frc && e_forced < 65535) e_forced++;
      if (bus.ctl_validout && bus.ctl_fetching && tq.size() != 0) begin
        tq[0].rem = tq[0].rem - 1;
        if (tq[0].rem == 0) void'(tq.pop_front());
      end
      if (hg && is_rd(bus.host_cmd)) tq.push_back('{scr: 1'b0, rem: beats(bus.host_cmd, bus.host_sz)});
      if (sg && is_rd(m_pcmd)) tq.push_back('{scr: 1'b1, rem: beats(m_pcmd, m_psz)});
      if (!m_pv || sg) m_starve = 0;
      else if (m_starve < SL) m_starve++;
      if (sg) begin
        m_pv = 0;
      end else if (!m_pv && bus.scr_cmd_put) begin
        m_pv = 1; m_phd = bus.scr_data_put; m_pcmd = bus.scr_cmd; m_psz = bus.scr_sz;
        m_paddr = bus.scr_addr; m_pdata = bus.scr_data_in;
      end
    end

    @(posedge clk);
    #1;
    check("ctl_cmd_put", bus.ctl_cmd_put, e_put);
    if (e_put) begin
      check("ctl_cmd", bus.ctl_cmd, e_cmd);
      check("ctl_sz", bus.ctl_sz, e_sz);
      check("ctl_addr", bus.ctl_addr, e_addr);
    end
    check("ctl_data_put", bus.ctl_data_put, e_dput);
    if (e_dput) check("ctl_data_in", bus.ctl_data_in, e_data);
    check("host_drop", host_drop, e_drop);
    check("tag_underflow", tag_underflow, e_under);
`ifdef DDR2_ARB_STATS_EN
    check("stat_scr_grants", stat_scr_grants, e_sg);
    check("stat_forced", stat_forced, e_forced);
`else
    check("stat_scr_grants", stat_scr_grants, 0);
    check("stat_forced", stat_forced, 0);
`endif
    @(negedge clk);
  endtask

  task automatic reset_step();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  int forced_at;

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    model_clear();
    check("rst_cmd_put", bus.ctl_cmd_put, 0);
    check("rst_data_put", bus.ctl_data_put, 0);
    check("rst_host_drop", host_drop, 0);
    check("rst_underflow", tag_underflow, 0);
    check("rst_host_notfull", bus.host_notfull, 1);
    check("rst_scr_notfull", bus.scr_notfull, 1);

    // Host SCW and scrub BLR in the same cycle: host first, scrub the next cycle
    bus.host_cmd = 3'b000; bus.host_addr = AW'('h100); bus.host_cmd_put = 1;
    bus.host_data_put = 1; bus.host_data_in = 64'hA5A5_0000_1111_2222;
    bus.scr_cmd = 3'b011; bus.scr_sz = 2'b00; bus.scr_addr = AW'('h200); bus.scr_cmd_put = 1;
    step();
    check("t1_host_addr", bus.ctl_addr, 'h100);
    idle_inputs();
    step();
    check("t1_scr_addr", bus.ctl_addr, 'h200);
    check("t1_scr_cmd", bus.ctl_cmd, 3'b011);
    check("t1_no_drop", host_drop, 0);

    // Host SCR behind the scrub BLR: 8 beats to the scrubber, the 9th to the host
    bus.host_cmd = 3'b001; bus.host_addr = AW'('h180); bus.host_cmd_put = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      bus.ctl_validout = 1; bus.host_fetching = 1; bus.scr_fetching = 1;
      bus.ctl_data_out = {$urandom, $urandom}; bus.ctl_raddr = AW'($urandom);
      step();
      check("t3_scr_beat", obs_sv, (i < 8));
      check("t3_host_beat", obs_hv, (i == 8));
    end
    idle_inputs();
    step();
    check("t3_no_underflow", tag_underflow, 0);
    check("t3_fifo_empty", bus.scr_notfull, 1);

    // Host puts every cycle against a pending scrub write: forced grant after SL waits
    forced_at = -1;
    bus.scr_cmd = 3'b000; bus.scr_addr = AW'('h3C0); bus.scr_cmd_put = 1;
    bus.scr_data_put = 1; bus.scr_data_in = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 8; i++) begin
      bus.host_cmd = 3'b010; bus.host_addr = AW'(i); bus.host_cmd_put = 1;
      step();
      bus.scr_cmd_put = 0; bus.scr_data_put = 0;
      if (!obs_hnf && forced_at < 0) forced_at = i;
    end
    check("t2_forced_cycle", forced_at, 1 + SL);
`ifdef DDR2_ARB_STATS_EN
    check("t2_stat_forced", stat_forced, 1);
`endif
    reset_step();

    // Host put while the controller is full: nothing issued, sticky drop
    bus.ctl_notfull = 0; bus.host_cmd = 3'b000; bus.host_cmd_put = 1;
    step();
    check("t5_no_issue", bus.ctl_cmd_put, 0);
    check("t5_drop", host_drop, 1);
    idle_inputs();
    repeat (3) step();
    check("t5_drop_sticky", host_drop, 1);
    reset_step();
    check("t5_drop_cleared", host_drop, 0);

    // Fill the tag FIFO with host reads; pending scrub read waits for one return
    for (int i = 0; i < TD; i++) begin
      bus.host_cmd = 3'b001; bus.host_addr = AW'(16 + i); bus.host_cmd_put = 1;
      if (i == TD - 1) begin
        bus.scr_cmd = 3'b001; bus.scr_addr = AW'('h300); bus.scr_cmd_put = 1;
      end
      step();
    end
    idle_inputs();
    repeat (2) begin
      step();
      check("t4_host_blocked", obs_hnf, 0);
      check("t4_scr_held", bus.ctl_cmd_put, 0);
    end
    bus.ctl_validout = 1; bus.host_fetching = 1;
    step();
    idle_inputs();
    step();
    check("t4_scr_granted", bus.ctl_cmd_put, 1);
    check("t4_scr_addr", bus.ctl_addr, 'h300);
    for (int i = 0; i < 50 && tq.size() != 0; i++) begin
      bus.ctl_validout = 1; bus.host_fetching = 1; bus.scr_fetching = 1;
      step();
    end
    check("t4_drained", tq.size(), 0);
    idle_inputs();

    // Reset mid scrub return burst discards tags; the next beat underflows to the host
    reset_step();
    bus.scr_cmd = 3'b011; bus.scr_sz = 2'b01; bus.scr_addr = AW'('h440); bus.scr_cmd_put = 1;
    step();
    idle_inputs();
    step();
    repeat (3) begin
      bus.ctl_validout = 1; bus.scr_fetching = 1;
      step();
    end
    reset_step();
    bus.ctl_validout = 1; bus.host_fetching = 1;
    step();
    check("t6_host_path", obs_hv, 1);
    check("t6_underflow", tag_underflow, 1);
    reset_step();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 199) == 0);
      bus.ctl_notfull   = ($urandom_range(0, 9) < 8);
      bus.ctl_ready     = ($urandom_range(0, 19) != 0);
      bus.host_cmd      = 3'($urandom);
      bus.host_sz       = 2'($urandom);
      bus.host_addr     = AW'($urandom);
      bus.host_cmd_put  = ($urandom_range(0, 9) < 4);
      bus.host_data_put = ($urandom_range(0, 9) < 2);
      bus.host_data_in  = {$urandom, $urandom};
      bus.scr_cmd       = 3'($urandom);
      bus.scr_sz        = 2'($urandom);
      bus.scr_addr      = AW'($urandom);
      bus.scr_cmd_put   = ($urandom_range(0, 9) < 3);
      bus.scr_data_put  = $urandom_range(0, 1);
      bus.scr_data_in   = {$urandom, $urandom};
      bus.ctl_validout  = (tq.size() != 0) && ($urandom_range(0, 1) == 1);
      bus.ctl_data_out  = {$urandom, $urandom};
      bus.ctl_raddr     = AW'($urandom);
      bus.host_fetching = ($urandom_range(0, 9) < 7);
      bus.scr_fetching  = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
